// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer: runs the IDLE/FETCH/EXEC/TRAP
// handshake with instruction memory and picks the next PC from the adder sums.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic        br_taken,
    input  logic        jalr,
    input  logic        stall,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic        inst_valid,
    output logic        trap,
    output logic [31:0] retire_cnt
);

    localparam int unsigned XLEN = 32;
    // Targets must sit on an instruction-step boundary.
    localparam logic [XLEN-1:0] ALIGN_MASK = PC_STEP - XLEN'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] retire_cnt_d;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;
    logic            imem_req_d;
    logic            inst_valid_d;
    logic            trap_d;

    // Next-PC select: jalr beats a taken branch, which beats sequential.
    always_comb begin
        next_pc = pc_plus4;
        if (jalr) begin
            next_pc = jalr_target & ~XLEN'(1);
        end else if (br_taken) begin
            next_pc = br_target;
        end
        misaligned = |(next_pc & ALIGN_MASK);
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc;
        retire_cnt_d = retire_cnt;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready) begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (misaligned) begin
                        state_d = S_TRAP;
                    end else begin
                        pc_d         = next_pc;
                        retire_cnt_d = retire_cnt + XLEN'(1);
                        state_d      = S_FETCH;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_req_d   = (state_d == S_FETCH);
        inst_valid_d = (state_d == S_EXEC);
        trap_d       = (state_d == S_TRAP);
    end

    // State, PC, counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc         <= RESET_PC;
            retire_cnt <= '0;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            trap       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc         <= pc_d;
            retire_cnt <= retire_cnt_d;
            imem_req   <= imem_req_d;
            inst_valid <= inst_valid_d;
            trap       <= trap_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed scenarios, a phase/PC/count model checked
// every cycle, and literal spot checks that pin the model.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] jalr_target;
    logic        br_taken;
    logic        jalr;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc;
    logic        imem_req;
    logic        inst_valid;
    logic        trap;
    logic [31:0] retire_cnt;

    int vectors;
    int miscompares;
    bit cmp_en;

    // Model: phase 0 idle, 1 fetch, 2 exec, 3 trap.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    pc_fetch_ctrl #(.RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_plus4    (pc_plus4),
        .br_target   (br_target),
        .jalr_target (jalr_target),
        .br_taken    (br_taken),
        .jalr        (jalr),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .pc          (pc),
        .imem_req    (imem_req),
        .inst_valid  (inst_valid),
        .trap        (trap),
        .retire_cnt  (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal external incrementer.
    assign pc_plus4 = m_pc + 32'd4;

    function automatic logic [31:0] redirect(input logic j, input logic b,
                                             input logic [31:0] jt, input logic [31:0] bt,
                                             input logic [31:0] seq);
        if (j) return {jt[31:1], 1'b0};
        if (b) return bt;
        return seq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_pc    <= 32'h0;
            m_cnt   <= 32'h0;
        end else begin
            if (m_phase == 0) begin
                m_phase <= 1;
            end else if (m_phase == 1) begin
                if (imem_ready) m_phase <= 2;
            end else if (m_phase == 2 && !stall) begin
                if (redirect(jalr, br_taken, jalr_target, br_target, pc_plus4) % 4 != 0) begin
                    m_phase <= 3;
                end else begin
                    m_pc    <= redirect(jalr, br_taken, jalr_target, br_target, pc_plus4);
                    m_cnt   <= m_cnt + 32'd1;
                    m_phase <= 1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model pc", pc, m_pc);
            check("model retire_cnt", retire_cnt, m_cnt);
            check("model imem_req", 32'(imem_req), 32'(m_phase == 1));
            check("model inst_valid", 32'(inst_valid), 32'(m_phase == 2));
            check("model trap", 32'(trap), 32'(m_phase == 3));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cmp_en      = 1'b0;
        rst_n       = 1'b0;
        br_target   = 32'h0;
        jalr_target = 32'h0;
        br_taken    = 1'b0;
        jalr        = 1'b0;
        stall       = 1'b0;
        imem_ready  = 1'b1;

        step(2);
        check("reset pc", pc, 32'h0);
        check("reset imem_req", 32'(imem_req), 32'h0);
        check("reset trap", 32'(trap), 32'h0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // Sequential stepping: first request one edge after release.
        step(1);
        check("first imem_req", 32'(imem_req), 32'h1);
        step(1);
        check("first inst_valid", 32'(inst_valid), 32'h1);
        step(5);
        check("seq pc", pc, 32'hC);
        check("seq retire_cnt", retire_cnt, 32'd3);

        // Taken branch at 0x10, then jalr priority with bit 0 cleared.
        step(3);
        check("pc before branch", pc, 32'h10);
        br_taken  = 1'b1;
        br_target = 32'h40;
        step(1);
        check("branch pc", pc, 32'h40);
        br_taken = 1'b0;
        step(1);
        jalr = 1'b1; jalr_target = 32'h81; br_taken = 1'b1; br_target = 32'h40;
        step(1);
        check("jalr pc", pc, 32'h80);
        br_taken = 1'b0;
        step(1);
        jalr_target = 32'h8;
        step(1);
        jalr = 1'b0;
        step(1);

        // Stall in EXEC at 0x8 with branch toggling.
        stall     = 1'b1;
        br_target = 32'h100;
        for (int i = 0; i < 5; i++) begin
            br_taken = ~br_taken;
            step(1);
            check("stall pc", pc, 32'h8);
            check("stall inst_valid", 32'(inst_valid), 32'h1);
            check("stall retire_cnt", retire_cnt, 32'd7);
        end
        stall    = 1'b0;
        br_taken = 1'b0;
        step(1);
        check("post-stall pc", pc, 32'hC);

        // Memory wait in FETCH.
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("wait imem_req", 32'(imem_req), 32'h1);
            check("wait inst_valid", 32'(inst_valid), 32'h0);
            check("wait pc", pc, 32'hC);
        end
        imem_ready = 1'b1;
        step(1);
        check("ready inst_valid", 32'(inst_valid), 32'h1);

        // Sequential wrap from 0xFFFF_FFFC to 0.
        jalr = 1'b1; jalr_target = 32'hFFFF_FFFD;
        step(1);
        check("pre-wrap pc", pc, 32'hFFFF_FFFC);
        jalr = 1'b0;
        step(2);
        check("wrap pc", pc, 32'h0);
        check("wrap trap", 32'(trap), 32'h0);
        check("wrap retire_cnt", retire_cnt, 32'd10);

        // Misaligned branch from 0x40 traps and stays trapped.
        step(1);
        jalr = 1'b1; jalr_target = 32'h40;
        step(1);
        jalr = 1'b0;
        step(1);
        br_taken = 1'b1; br_target = 32'h22;
        step(1);
        br_taken = 1'b0;
        check("trap flag", 32'(trap), 32'h1);
        check("trap pc", pc, 32'h40);
        step(5);
        check("trap held", 32'(trap), 32'h1);
        check("trap imem_req", 32'(imem_req), 32'h0);
        check("trap retire_cnt", retire_cnt, 32'd11);

        rst_n = 1'b0;
        #1;
        check("trap reset pc", pc, 32'h0);
        check("trap reset trap", 32'(trap), 32'h0);
        check("trap reset retire_cnt", retire_cnt, 32'h0);
        step(1);
        rst_n = 1'b1;

        // Asynchronous reset while a fetch is outstanding at 0x8.
        step(5);
        imem_ready = 1'b0;
        step(1);
        check("mid-fetch pc", pc, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        check("async pc", pc, 32'h0);
        check("async imem_req", 32'(imem_req), 32'h0);
        check("async inst_valid", 32'(inst_valid), 32'h0);
        check("async retire_cnt", retire_cnt, 32'h0);
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
